char_ctrl: RTL and testbench

Per-frame motion controller for the player sprite. It samples movement buttons, runs a ground/jump/fall state machine with gravity, and clamps the sprite to the screen. It drives the sprite drawer's pos_x, pos_y and flip_h inputs. It sits between the input synchroniser and the character draw stage, and updates state once per frame on the vblank rising edge.

---
 rtl/char_pkg.sv | 13 +
 rtl/vga_pkg.sv | 6 +
 rtl/edge_detect.sv | 17 +
 rtl/char_ctrl.sv | 148 ++++++++++++++
 tb/tb_char_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/char_pkg.sv
// Player sprite geometry and motion state, shared by control and draw.
// CHAR_HGT / CHAR_LNG are half-height / half-width; no ports.
package char_pkg;
  localparam int CHAR_HGT      = 26;
  localparam int CHAR_LNG      = 19;
  localparam int GROUND_OFFSET = 20;

  typedef enum logic [1:0] {
    GROUND,
    RISING,
    FALLING
  } char_state_t;
endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the timing, draw and control stages.
// Holds the active-area size in pixels; no ports.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator: pulse is high for the cycle where in
// goes 0->1. Ports: clk, rst (sync, high), in, pulse.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic in_d;

  always_ff @(posedge clk) begin
    if (rst) in_d <= 1'b0;
    else     in_d <= in;
  end

  assign pulse = in & ~in_d;
endmodule

// File: rtl/char_ctrl.sv
// Per-frame player motion: walk, jump/fall with gravity, screen clamp.
// In: clk, rst, vblnk, btn_left/right/jump. Out: pos_x, pos_y, flip_h, in_air.
module char_ctrl
  import vga_pkg::*;
  import char_pkg::*;
#(
  parameter int MOVE_STEP = 4,
  parameter int JUMP_V0   = 12,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 12,
  parameter int HALF_W    = CHAR_LNG,
  parameter int HALF_H    = CHAR_HGT,
  parameter int GROUND_Y  = VER_PIXELS - GROUND_OFFSET - CHAR_HGT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        flip_h,
  output logic        in_air
);
  localparam logic signed [12:0] STEP  = 13'(MOVE_STEP);
  localparam logic signed [12:0] X_MIN = 13'(HALF_W);
  localparam logic signed [12:0] X_MAX = 13'(HOR_PIXELS - HALF_W);
  localparam logic signed [12:0] Y_MIN = 13'(HALF_H);
  localparam logic signed [12:0] Y_MAX = 13'(GROUND_Y);
  localparam logic [4:0]  V0    = 5'(JUMP_V0);
  localparam logic [4:0]  GRAV  = 5'(GRAVITY);
  localparam logic [4:0]  VMAX  = 5'(MAX_FALL);
  localparam logic [11:0] X_RST = 12'(HOR_PIXELS / 2);
  localparam logic [11:0] Y_RST = 12'(GROUND_Y);
  localparam logic [11:0] Y_TOP = 12'(HALF_H);

  char_state_t state, state_n;
  logic [4:0]  vel, vel_n;
  logic [11:0] x_n, y_n;
  logic        flip_n;
  logic        jump_req;
  logic        tick, jump_edge, go;

  logic signed [12:0] x_s, y_s, x_t, y_t;
  logic [4:0]  v_inc, v_dec, v_f;

  edge_detect u_tick (
    .clk   (clk),
    .rst   (rst),
    .in    (vblnk),
    .pulse (tick)
  );

  edge_detect u_jump (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_jump),
    .pulse (jump_edge)
  );

  // An edge landing on the tick cycle is used by that tick.
  assign go = jump_req | jump_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GROUND;
      vel      <= '0;
      pos_x    <= X_RST;
      pos_y    <= Y_RST;
      flip_h   <= 1'b0;
      in_air   <= 1'b0;
      jump_req <= 1'b0;
    end else if (tick) begin
      state    <= state_n;
      vel      <= vel_n;
      pos_x    <= x_n;
      pos_y    <= y_n;
      flip_h   <= flip_n;
      in_air   <= (state_n != GROUND);
      jump_req <= 1'b0;
    end else if (jump_edge) begin
      jump_req <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    vel_n   = vel;
    flip_n  = flip_h;
    x_s     = {1'b0, pos_x};
    y_s     = {1'b0, pos_y};
    x_t     = x_s;
    y_t     = y_s;
    y_n     = pos_y;
    v_inc   = vel + GRAV;
    v_dec   = vel - GRAV;
    v_f     = (v_inc > VMAX) ? VMAX : v_inc;

    unique case (1'b1)
      btn_left && !btn_right: begin
        x_t    = x_s - STEP;
        x_t    = (x_t < X_MIN) ? X_MIN : x_t;
        flip_n = 1'b1;
      end
      btn_right && !btn_left: begin
        x_t    = x_s + STEP;
        x_t    = (x_t > X_MAX) ? X_MAX : x_t;
        flip_n = 1'b0;
      end
      default: ;
    endcase
    x_n = x_t[11:0];

    case (state)
      GROUND: begin
        if (go) begin
          vel_n   = V0;
          state_n = RISING;
        end
      end
      RISING: begin
        y_t = y_s - $signed({8'b0, vel});
        if (y_t < Y_MIN) begin
          y_n     = Y_TOP;
          vel_n   = '0;
          state_n = FALLING;
        end else begin
          y_n   = y_t[11:0];
          vel_n = v_dec;
          if (v_dec == '0) state_n = FALLING;
        end
      end
      FALLING: begin
        y_t = y_s + $signed({8'b0, v_f});
        if (y_t >= Y_MAX) begin
          y_n     = Y_RST;
          vel_n   = '0;
          state_n = GROUND;
        end else begin
          y_n   = y_t[11:0];
          vel_n = v_f;
        end
      end
      default: state_n = GROUND;
    endcase
  end
endmodule

// File: tb/tb_char_ctrl.sv
// Bench for char_ctrl: per-cycle model compare plus literal checks.
// Drives inputs 1 time unit after posedge, compares on negedge.
module tb_char_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_jump = 1'b0;
  logic [11:0] pos_x, pos_y;
  logic        flip_h, in_air;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model state: vy is a signed downward velocity (negative = going up).
  int m_x, m_y, m_vy;
  bit m_flip, m_air, m_req, m_pv, m_pj;

  char_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk     (vblnk),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .flip_h    (flip_h),
    .in_air    (in_air)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bit t, je;
    if (rst) begin
      m_x = 400; m_y = 554; m_vy = 0;
      m_flip = 0; m_air = 0; m_req = 0;
      m_pv = 0; m_pj = 0;
    end else begin
      t  = vblnk && !m_pv;
      je = btn_jump && !m_pj;
      if (t) begin
        if (btn_left && !btn_right) begin
          m_x = (m_x - 4 < 19) ? 19 : m_x - 4;
          m_flip = 1;
        end else if (btn_right && !btn_left) begin
          m_x = (m_x + 4 > 781) ? 781 : m_x + 4;
          m_flip = 0;
        end
        if (!m_air) begin
          if (m_req || je) begin
            m_vy = -12;
            m_air = 1;
          end
        end else if (m_vy < 0) begin
          m_y = m_y + m_vy;
          if (m_y < 26) begin
            m_y = 26;
            m_vy = 0;
          end else begin
            m_vy = m_vy + 1;
          end
        end else begin
          m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1;
          m_y = m_y + m_vy;
          if (m_y >= 554) begin
            m_y = 554;
            m_vy = 0;
            m_air = 0;
          end
        end
        m_req = 0;
      end else if (je) begin
        m_req = 1;
      end
      m_pv = vblnk;
      m_pj = btn_jump;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (pos_x !== 12'(m_x) || pos_y !== 12'(m_y) ||
          flip_h !== m_flip || in_air !== m_air) begin
        bad++;
        $display("FAIL model t=%0t got x=%0d y=%0d f=%b a=%b want x=%0d y=%0d f=%b a=%b",
                 $time, pos_x, pos_y, flip_h, in_air,
                 m_x, m_y, m_flip, m_air);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  // One frame: vblnk high for hi cycles, then low for one.
  task automatic frame(input int hi = 1);
    vblnk = 1'b1;
    repeat (hi) @(posedge clk);
    #1 vblnk = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_jump();
    btn_jump = 1'b1;
    @(posedge clk);
    #1 btn_jump = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int ytab[25] = '{554, 542, 531, 521, 512, 504, 497, 491, 486, 482,
                   479, 477, 476, 477, 479, 482, 486, 491, 497, 504,
                   512, 521, 531, 542, 554};

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    rst = 1'b0;

    chk("rst_x", pos_x, 400);
    chk("rst_y", pos_y, 554);
    chk("rst_flip", flip_h, 0);
    chk("rst_air", in_air, 0);
    frame(); frame();
    chk("idle_x", pos_x, 400);
    chk("idle_y", pos_y, 554);

    btn_right = 1'b1;
    frame(); chk("right1", pos_x, 404);
    frame(); chk("right2", pos_x, 408);
    frame(); chk("right3", pos_x, 412);
    chk("right_flip", flip_h, 0);
    btn_left = 1'b1;
    frame(); chk("both_x", pos_x, 412);
    btn_left = 1'b0;

    repeat (93) frame();
    chk("right_clamp", pos_x, 781);
    btn_right = 1'b0;
    btn_left = 1'b1;
    repeat (190) frame();
    chk("left_21", pos_x, 21);
    frame(); chk("left_19a", pos_x, 19);
    frame(); chk("left_19b", pos_x, 19);
    chk("left_flip", flip_h, 1);
    btn_left = 1'b0;
    btn_right = 1'b1;
    repeat (190) frame();
    chk("right_779", pos_x, 779);
    frame(); chk("right_781a", pos_x, 781);
    frame(); chk("right_781b", pos_x, 781);
    chk("right_flip2", flip_h, 0);
    btn_right = 1'b0;

    pulse_jump();
    for (int i = 0; i < 25; i++) begin
      frame();
      chk($sformatf("jump_y%0d", i + 1), pos_y, ytab[i]);
      chk($sformatf("jump_air%0d", i + 1), in_air, (i < 24) ? 1 : 0);
    end

    pulse_jump();
    repeat (3) frame();
    chk("mid_y", pos_y, 531);
    pulse_jump();
    btn_left = 1'b1;
    frame(100);
    chk("long_x", pos_x, 777);
    chk("long_y", pos_y, 521);
    btn_left = 1'b0;
    repeat (21) frame();
    chk("land_y", pos_y, 554);
    chk("land_air", in_air, 0);
    repeat (3) frame();
    chk("nodbl_y", pos_y, 554);
    chk("nodbl_air", in_air, 0);

    pulse_jump();
    repeat (13) frame();
    chk("peak_y", pos_y, 476);
    chk("peak_air", in_air, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_y", pos_y, 554);
    chk("rst2_x", pos_x, 400);
    chk("rst2_air", in_air, 0);
    rst = 1'b0;
    frame();
    chk("post_rst_y", pos_y, 554);
    chk("post_rst_air", in_air, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
